// File: rtl/gcd_multilane.sv
// gcd_multilane: els_p subtractive-Euclid GCD lanes behind one valid/ready input
// and one valid/yumi output. Jobs dispatch round-robin and retire in issue order.
module gcd_multilane #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [2*width_p-1:0]       data_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output logic [width_p-1:0]         data_o,
    output logic                       v_o,
    input  logic                       yumi_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    // Handshake: a job is accepted at a rising edge where v_i & ready_o; a result
    // is retired at a rising edge where yumi_i & v_o. yumi_i without v_o is ignored.

    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_BUSY = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_e;

    logic [ptr_w-1:0]                wr_ptr;
    logic [ptr_w-1:0]                rd_ptr;
    logic [cnt_w-1:0]                count_q;
    logic [els_p-1:0]                wr_sel;
    logic [els_p-1:0]                rd_sel;
    logic [els_p-1:0]                lane_idle;
    logic [els_p-1:0]                lane_done;
    logic [els_p-1:0][width_p-1:0]   lane_result;
    logic                            accept;
    logic                            retire;
    logic [width_p-1:0]              op_a_in;
    logic [width_p-1:0]              op_b_in;

    assign op_a_in = data_i[width_p-1:0];
    assign op_b_in = data_i[2*width_p-1:width_p];

    // ready_o and v_o decode only registered lane state and the pointers.
    always_comb begin
        ready_o = !reset_i && (|(lane_idle & wr_sel));
        v_o     = |(lane_done & rd_sel);
        data_o  = '0;
        for (int i = 0; i < els_p; i++) begin
            if (rd_sel[i]) begin
                data_o = lane_result[i];
            end
        end
    end

    assign accept  = v_i & ready_o;
    assign retire  = yumi_i & v_o;
    assign count_o = count_q;

    for (genvar i = 0; i < els_p; i++) begin : g_lane
        lane_state_e        state_q;
        logic [width_p-1:0] a_q;
        logic [width_p-1:0] b_q;
        logic [width_p-1:0] result_q;

        assign wr_sel[i]      = (wr_ptr == ptr_w'(i));
        assign rd_sel[i]      = (rd_ptr == ptr_w'(i));
        assign lane_idle[i]   = (state_q == LANE_IDLE);
        assign lane_done[i]   = (state_q == LANE_DONE);
        assign lane_result[i] = result_q;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                state_q  <= LANE_IDLE;
                a_q      <= '0;
                b_q      <= '0;
                result_q <= '0;
            end else begin
                case (state_q)
                    LANE_IDLE: begin
                        if (accept && wr_sel[i]) begin
                            a_q     <= op_a_in;
                            b_q     <= op_b_in;
                            state_q <= LANE_BUSY;
                        end
                    end
                    LANE_BUSY: begin
                        // Zero checks come first so gcd(x,0) and gcd(0,x) end in one step.
                        if (a_q == '0) begin
                            result_q <= b_q;
                            state_q  <= LANE_DONE;
                        end else if (b_q == '0) begin
                            result_q <= a_q;
                            state_q  <= LANE_DONE;
                        end else if (a_q == b_q) begin
                            result_q <= a_q;
                            state_q  <= LANE_DONE;
                        end else if (a_q > b_q) begin
                            a_q <= a_q - b_q;
                        end else begin
                            b_q <= b_q - a_q;
                        end
                    end
                    LANE_DONE: begin
                        if (retire && rd_sel[i]) begin
                            state_q <= LANE_IDLE;
                        end
                    end
                    default: state_q <= LANE_IDLE;
                endcase
            end
        end
    end

    // Round-robin pointers; occupied lanes always form a contiguous run from rd_ptr.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            end
            if (retire) begin
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
            end
            if (accept && !retire) begin
                count_q <= count_q + 1'b1;
            end else if (!accept && retire) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_multilane.sv
// Bench for gcd_multilane: three instances (els_p 1, 3, 4; width_p 16) checked every
// cycle against a queue-based GCD model, plus directed scenarios on the 4-lane instance.
module tb_gcd_multilane;

    localparam int W = 16;
    localparam int ELS [3] = '{1, 3, 4};
    localparam int D = 2;

    logic          clk;
    logic          rst;
    logic [2*W-1:0] data_in   [3];
    logic          v_in      [3];
    logic          yumi_in   [3];
    logic          ready_out [3];
    logic          v_out     [3];
    logic [W-1:0]  data_out  [3];
    logic [2:0]    count_out [3];

    int n_tests = 0;
    int n_fails = 0;
    int cyc = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int sub_steps(input int a, input int b);
        int k = 0;
        while (!(a == 0 || b == 0 || a == b)) begin
            if (a > b) a = a - b;
            else       b = b - a;
            k++;
        end
        return k;
    endfunction

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s (els_p=%0d) at cycle %0d: got %0d, expected %0d",
                     name, ELS[g], cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int g);
        n_tests++;
        n_fails++;
        $display("FAIL %s (els_p=%0d) timed out at cycle %0d", name, ELS[g], cyc);
    endtask

    // ---------------- DUTs and per-instance scoreboards ----------------
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [$clog2(ELS[g]+1)-1:0] cnt_l;
        logic [W-1:0] exp_q[$];
        int due_q[$];
        int mcnt = 0;

        gcd_multilane #(.width_p(W), .els_p(ELS[g])) u_dut (
            .clk_i   (clk),
            .reset_i (rst),
            .data_i  (data_in[g]),
            .v_i     (v_in[g]),
            .ready_o (ready_out[g]),
            .data_o  (data_out[g]),
            .v_o     (v_out[g]),
            .yumi_i  (yumi_in[g]),
            .count_o (cnt_l)
        );
        assign count_out[g] = 3'(cnt_l);

        always @(negedge clk) begin : cmp
            logic exp_v;
            logic acc;
            logic ret;
            int a;
            int b;
            if (rst) begin
                exp_q.delete();
                due_q.delete();
                mcnt = 0;
            end else begin
                exp_v = (exp_q.size() != 0) && (due_q[0] <= cyc);
                check("v_o", g, 32'(v_out[g]), 32'(exp_v));
                if (exp_v) check("data_o", g, 32'(data_out[g]), 32'(exp_q[0]));
                check("count_o", g, 32'(count_out[g]), mcnt);
                check("ready_o", g, 32'(ready_out[g]), 32'(mcnt < ELS[g]));
                ret = yumi_in[g] && exp_v;
                acc = v_in[g] && (mcnt < ELS[g]);
                if (ret) begin
                    void'(exp_q.pop_front());
                    void'(due_q.pop_front());
                    mcnt--;
                end
                if (acc) begin
                    a = int'(data_in[g][W-1:0]);
                    b = int'(data_in[g][2*W-1:W]);
                    exp_q.push_back(W'(ref_gcd(a, b)));
                    due_q.push_back(cyc + 2 + sub_steps(a, b));
                    mcnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int g, input int a, input int b);
        int guard = 0;
        data_in[g] = {W'(b), W'(a)};
        v_in[g] = 1'b1;
        while (!ready_out[g] && guard < 2000) begin
            step();
            guard++;
        end
        if (guard >= 2000) timeout("offer", g);
        step();
        v_in[g] = 1'b0;
    endtask

    task automatic wait_v(input int g, input int budget);
        int guard = 0;
        while (!v_out[g] && guard < budget) begin
            step();
            guard++;
        end
        if (guard >= budget) timeout("wait_v", g);
    endtask

    function automatic logic [2*W-1:0] rand_ops();
        int a;
        int b;
        int f;
        case ($urandom_range(0, 3))
            0: begin
                a = $urandom_range(0, 3);
                b = $urandom_range(0, 3);
            end
            1, 3: begin
                f = $urandom_range(1, 15);
                a = f * $urandom_range(0, 20);
                b = f * $urandom_range(0, 20);
            end
            default: begin
                a = $urandom_range(0, 255);
                b = $urandom_range(0, 255);
            end
        endcase
        return {W'(b), W'(a)};
    endfunction

    task automatic drive_random(input int g, input int n);
        int issued = 0;
        int guard = 0;
        logic acc;
        v_in[g] = 1'b0;
        yumi_in[g] = 1'b0;
        while ((issued < n || count_out[g] != 0) && guard < 20000) begin
            if (!v_in[g] && issued < n && $urandom_range(0, 99) < 70) begin
                data_in[g] = rand_ops();
                v_in[g] = 1'b1;
            end
            yumi_in[g] = v_out[g] && ($urandom_range(0, 99) < 60);
            acc = v_in[g] && ready_out[g];
            step();
            guard++;
            if (acc) begin
                issued++;
                v_in[g] = 1'b0;
            end
        end
        v_in[g] = 1'b0;
        yumi_in[g] = 1'b0;
        if (guard >= 20000) timeout("random_drain", g);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin : main
        int za [3] = '{0, 9, 0};
        int zb [3] = '{7, 0, 0};
        int zr [3] = '{7, 9, 0};
        int full_exp [4] = '{3, 7, 25, 7};
        int idx;
        int guard;

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            data_in[g] = '0;
            v_in[g] = 1'b0;
            yumi_in[g] = 1'b0;
        end

        // Model pins.
        check("model_gcd_12_8", 0, ref_gcd(12, 8), 4);
        check("model_steps_12_8", 0, sub_steps(12, 8), 2);
        check("model_gcd_0_0", 0, ref_gcd(0, 0), 0);
        check("model_steps_1000_1", 0, sub_steps(1000, 1), 999);

        // Reset state.
        repeat (3) step();
        check("rst_ready", D, ready_out[D], 0);
        check("rst_v", D, v_out[D], 0);
        check("rst_count", D, count_out[D], 0);
        check("rst_data", D, data_out[D], 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", D, ready_out[D], 1);
        check("post_rst_v", D, v_out[D], 0);
        check("post_rst_count", D, count_out[D], 0);

        // Single job: (12,8) -> 4 at accept+4.
        offer(D, 12, 8);
        check("single_v_t1", D, v_out[D], 0);
        check("single_cnt_t1", D, count_out[D], 1);
        step();
        check("single_v_t2", D, v_out[D], 0);
        step();
        check("single_v_t3", D, v_out[D], 0);
        step();
        check("single_v_t4", D, v_out[D], 1);
        check("single_data_t4", D, data_out[D], 4);
        yumi_in[D] = 1'b1;
        step();
        yumi_in[D] = 1'b0;
        check("single_cnt_after", D, count_out[D], 0);
        check("single_v_after", D, v_out[D], 0);

        // Zero operands finish on the first step.
        for (int i = 0; i < 3; i++) begin
            offer(D, za[i], zb[i]);
            check("zero_v_t1", D, v_out[D], 0);
            step();
            check("zero_v_t2", D, v_out[D], 1);
            check("zero_data", D, data_out[D], zr[i]);
            yumi_in[D] = 1'b1;
            step();
            yumi_in[D] = 1'b0;
        end

        // Ordering: slow job first, fast job second.
        offer(D, 1000, 1);
        offer(D, 5, 5);
        repeat (10) step();
        check("order_hold_v", D, v_out[D], 0);
        wait_v(D, 1200);
        check("order_first", D, data_out[D], 1);
        yumi_in[D] = 1'b1;
        step();
        yumi_in[D] = 1'b0;
        check("order_second_v", D, v_out[D], 1);
        check("order_second", D, data_out[D], 5);
        yumi_in[D] = 1'b1;
        step();
        yumi_in[D] = 1'b0;

        // Full / backpressure with five jobs on four lanes.
        offer(D, 12, 8);
        offer(D, 9, 6);
        offer(D, 35, 21);
        offer(D, 100, 75);
        data_in[D] = {16'd21, 16'd14};
        v_in[D] = 1'b1;
        step();
        step();
        check("full_ready", D, ready_out[D], 0);
        check("full_count", D, count_out[D], 4);
        wait_v(D, 200);
        check("full_first", D, data_out[D], 4);
        yumi_in[D] = 1'b1;
        step();
        yumi_in[D] = 1'b0;
        check("full_ready_after_retire", D, ready_out[D], 1);
        check("full_count_after_retire", D, count_out[D], 3);
        step();
        v_in[D] = 1'b0;
        check("full_count_refill", D, count_out[D], 4);
        idx = 0;
        guard = 0;
        while (idx < 4 && guard < 500) begin
            yumi_in[D] = v_out[D];
            if (v_out[D]) begin
                check("full_drain", D, data_out[D], full_exp[idx]);
                idx++;
            end
            step();
            guard++;
        end
        yumi_in[D] = 1'b0;
        if (guard >= 500) timeout("full_drain", D);
        check("full_count_empty", D, count_out[D], 0);

        // Reset mid-operation.
        offer(D, 1000, 3);
        offer(D, 999, 2);
        offer(D, 500, 7);
        rst = 1'b1;
        step();
        check("midrst_v", D, v_out[D], 0);
        check("midrst_count", D, count_out[D], 0);
        check("midrst_ready", D, ready_out[D], 0);
        rst = 1'b0;
        #1;
        check("midrst_ready_after", D, ready_out[D], 1);
        check("midrst_count_after", D, count_out[D], 0);
        offer(D, 21, 14);
        wait_v(D, 100);
        check("midrst_result", D, data_out[D], 7);
        yumi_in[D] = 1'b1;
        step();
        yumi_in[D] = 1'b0;

        // Random regression on all three lane counts concurrently.
        fork
            drive_random(0, 120);
            drive_random(1, 150);
            drive_random(2, 150);
        join
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin : watchdog
        #800000;
        n_tests++;
        n_fails++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule

// File: doc/gcd_multilane.md
# gcd_multilane

Parametrised multi-lane successor to the single-engine GCD datapath. It holds `els_p` independent subtractive-Euclid GCD engines behind one valid/ready input port and one valid/yumi output port. Jobs are dispatched to lanes round-robin and retired strictly in issue order, so several GCDs run concurrently while the stream stays ordered. It sits between the trace-replay source/sink in the bench, and between fabric endpoints in the chip, in place of the single-lane unit.

## Interface
- `width_p`, default 32: operand and result width.
- `els_p`, default 4: number of lanes. Any value ≥1; not restricted to powers of two.
- `clk_i  input  1`: the single clock; all state updates on its rising edge.
- `reset_i  input  1`: synchronous, active-high reset.
- `data_i  input  2*width_p`: operand a = `data_i[width_p-1:0]`, operand b = `data_i[2*width_p-1:width_p]`.
- `v_i  input  1`: input job valid.
- `ready_o  output  1`: a lane is free to accept a job.
- `data_o  output  width_p`: GCD result of the oldest outstanding job.
- `v_o  output  1`: `data_o` is valid.
- `yumi_i  input  1`: consumer takes `data_o` this cycle. Legal only while `v_o`=1.
- `count_o  output  $clog2(els_p+1)`: number of jobs accepted and not yet retired.

## Operation
- Per-lane state machine: IDLE -> BUSY on accept; BUSY -> DONE on termination; DONE -> IDLE on retire.
- Write pointer `wr_ptr` (0..els_p-1):
  - `ready_o` = lane[`wr_ptr`] is IDLE and `reset_i`=0.
  - Accept = `v_i & ready_o`. Accept loads a/b into lane[`wr_ptr`] and advances `wr_ptr`, wrapping from els_p-1 to 0.
- Read pointer `rd_ptr`:
  - `v_o` = lane[`rd_ptr`] is DONE.
  - `data_o` = that lane's result register.
  - Retire = `yumi_i & v_o`. Retire sets the lane to IDLE and advances `rd_ptr` with wrap.
  - `yumi_i` while `v_o`=0 is ignored.
- BUSY step, one per cycle, evaluated in this priority order:
  1. a==0: result = b, go to DONE.
  2. b==0: result = a, go to DONE.
  3. a==b: result = a, go to DONE.
  4. a>b: a <= a-b.
  5. Otherwise: b <= b-a.
- Arithmetic is unsigned, `width_p` bits. No overflow is possible. gcd(0,0)=0.
- Lanes finishing out of order stay in DONE until their turn. Completion order never affects output order.
- `count_o` increments on accept and decrements on retire. A simultaneous accept and retire leaves it unchanged.
- Full: all lanes non-IDLE, so `ready_o`=0 and `count_o`=els_p.
- Empty: `count_o`=0 and `v_o`=0.
- There is no bypass. A lane retired in cycle t can be re-accepted no earlier than t+1, because `ready_o` sees IDLE only after the edge.
- `els_p`=1 degenerates to the single-engine behaviour with the same latency.

## Timing
- Reset values, which hold while `reset_i`=1 and in the first cycle after release:
  - All lanes IDLE, `wr_ptr`=`rd_ptr`=0, operand/result registers 0.
  - `v_o`=0, `data_o`=0, `count_o`=0.
  - `ready_o`=0 while `reset_i`=1, and 1 in the first cycle after release.
- Reset mid-operation discards every in-flight and DONE job with no output. Accept or yumi in a reset cycle has no effect.
- Latency, with accept at edge t (lane BUSY during cycle t+1):
  - Job terminating on its first step: `v_o` high in cycle t+2.
  - In general: `v_o` in cycle t+2+k, where k = number of subtraction steps, provided all older jobs have retired.
- Throughput: one accept and one retire per cycle, concurrently.
- `data_o` is stable while `v_o`=1 and `yumi_i`=0.
- All outputs are registered or decoded from registered lane state. No combinational path runs from `v_i`/`yumi_i` to `ready_o`/`v_o`.

## Test plan
- Single job, els_p=4: (a=12, b=8) accepted at t -> `v_o`=1, `data_o`=4 at t+4; yumi -> `count_o` 1 -> 0, `v_o`=0 the next cycle.
- Zero operands: (0,7) -> 7; (9,0) -> 9; (0,0) -> 0. Each gives `v_o` at accept+2.
- Ordering: issue (1000,1) then (5,5) back-to-back. Lane 1 reaches DONE first but `v_o` stays 0 until 1 is delivered. Then 5 follows, asserted the cycle after retire of 1.
- Full/backpressure: `yumi_i`=0 and 5 jobs offered with els_p=4 -> 4 accepted, `ready_o`=0, `count_o`=4. Fifth accepted the cycle after the first retire. All 5 results come out in issue order.
- Reset mid-operation: 3 jobs in flight, assert `reset_i` for 1 cycle -> `v_o`=0, `count_o`=0, `ready_o`=0 during reset and 1 after. The next job lands in lane 0 and its result is correct.
- Random regression, width_p=16 and els_p ∈ {1,3,4}: random `v_i`/`yumi_i` -> output stream matches a reference-model GCD queue, and `count_o` matches accepts minus retires every cycle.
